// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit scheduler
package uart_pkg;

  typedef enum logic [2:0] {
    SCH_IDLE      = 3'd0,
    SCH_LAUNCH    = 3'd1,
    SCH_WAIT_BUSY = 3'd2,
    SCH_WAIT_DONE = 3'd3,
    SCH_GAP       = 3'd4
  } sch_state_e;

  localparam int UART_CLK_FREQ = 100_000_000;
  localparam int UART_BAUD     = 9600;
  localparam int REQ_MAX       = 8;

  // Returns {found, index} of the first set bit of req at or after ptr, wrapping at n.
  function automatic logic [3:0] rr_first(input logic [REQ_MAX-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int                 n);
    logic [3:0] res;
    int         idx;
    res = 4'b0;
    for (int k = 0; k < REQ_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !res[3] && req[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, occupancy count and full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Flush wins over both push and pop at the same edge.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= wdata_i;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte arbiter and frame sequencer in front of one UART transmitter
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DataWidth  = 8,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_TMO   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DataWidth-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  input  logic                         flush,
  output logic [DataWidth-1:0]         tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         tmo_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TMO+1);
  localparam int GW = $clog2(GAP_CYCLES+1);

  sch_state_e          state_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       rr_ptr_d;
  logic [NUM_REQ-1:0]  req_ack_q;
  logic [DataWidth-1:0] tx_data_q;
  logic                tx_start_q;
  logic                tmo_err_q;
  logic [TW-1:0]       tmo_cnt_q;
  logic [GW-1:0]       gap_cnt_q;

  logic [3:0]          pick;
  logic                grant;
  logic [PW-1:0]       gidx;
  logic [DataWidth-1:0] push_data;
  logic                pop;
  logic [DataWidth-1:0] head_data;

  // Full is judged on the registered count, so a same-edge pop never frees a slot early.
  assign pick      = rr_first(REQ_MAX'(req), 3'(rr_ptr_q), NUM_REQ);
  assign grant     = pick[3] && !fifo_full && !flush;
  assign gidx      = PW'(pick[2:0]);
  assign push_data = req_data[gidx*DataWidth +: DataWidth];
  assign pop       = (state_q == SCH_IDLE) && !fifo_empty && !flush;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      req_ack_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      req_ack_q <= grant ? (NUM_REQ'(1) << gidx) : '0;
    end
  end

  sync_fifo #(
    .WIDTH (DataWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (grant),
    .wdata_i (push_data),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCH_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      case (state_q)
        SCH_IDLE: begin
          if (pop) begin
            tx_data_q <= head_data;
            state_q   <= SCH_LAUNCH;
          end
        end
        SCH_LAUNCH: begin
          tx_start_q <= 1'b1;
          tmo_cnt_q  <= '0;
          state_q    <= SCH_WAIT_BUSY;
        end
        SCH_WAIT_BUSY: begin
          if (tx_busy) begin
            tmo_cnt_q <= '0;
            state_q   <= SCH_WAIT_DONE;
          end else if (tmo_cnt_q == TW'(BUSY_TMO-1)) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b1;
            state_q   <= SCH_GAP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        SCH_WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= SCH_GAP;
          end
        end
        SCH_GAP: begin
          if (gap_cnt_q == GW'(GAP_CYCLES-1)) begin
            gap_cnt_q <= '0;
            state_q   <= SCH_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          gap_cnt_q <= '0;
          tmo_cnt_q <= '0;
          state_q   <= SCH_IDLE;
        end
      endcase
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed and randomized bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              flush;
  logic [DW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [2:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tmo_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_start = -1;
  bit auto_busy = 0;
  int busy_rem  = 0;
  int busy_min  = 5;
  int busy_max  = 5;
  logic [DW-1:0] sent[$];
  logic [DW-1:0] exp_q[$];
  int ack_order[$];

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(NREQ), .DataWidth(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
    .flush(flush), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .tmo_err(tmo_err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; the transmitter model reacts to tx_start and drives tx_busy for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start === 1'b1) begin
      chk("no_start_while_busy", 32'(tx_busy), 0);
      sent.push_back(tx_data);
      last_start = cyc;
      if (auto_busy) busy_rem = $urandom_range(busy_max, busy_min);
    end
    if (auto_busy) begin
      tx_busy = (busy_rem > 0);
      if (busy_rem > 0) busy_rem--;
    end
  endtask

  task automatic set_req(int i, logic [DW-1:0] d);
    req[i] = 1'b1;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_data = '0; flush = 1'b0; tx_busy = 1'b0;
    auto_busy = 0; busy_rem = 0; busy_min = 5; busy_max = 5;
    repeat (3) tick();
    rst = 1'b0;
    sent.delete();
  endtask

  task automatic run_acks(string tag, int n);
    int got = 0;
    ack_order.delete();
    for (int b = 0; b < 200 && got < n; b++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] === 1'b1) begin
          ack_order.push_back(i);
          got++;
          req[i] = 1'b0;
        end
      end
    end
    chk(tag, got, n);
  endtask

  task automatic wait_sent(string tag, int n, int budget);
    for (int b = 0; b < budget && sent.size() < n; b++) tick();
    chk(tag, sent.size(), n);
  endtask

  task automatic check_sent(string tag);
    chk({tag, "_count"}, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      chk({tag, "_byte"}, 32'(sent[i]), 32'(exp_q[i]));
    end
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] r, int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    int k0, fall, p, a, tmo_cyc, g, rr_m;
    bit renewed, gen;
    logic [NREQ-1:0] req_edge;
    logic [DW-1:0] hold [NREQ];

    // Reset values
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    rst = 1'b0;

    // Single byte, latency, frame hold and gap
    do_reset();
    set_req(2, 8'hA5);
    tick();
    chk("t1_ack", 32'(req_ack), 32'h4);
    req[2] = 1'b0;
    k0 = cyc;
    wait_sent("t1_start_seen", 1, 20);
    chk("t1_latency", last_start - k0, 2);
    chk("t1_data", 32'(tx_data), 32'hA5);
    tick();
    chk("t1_start_pulse", 32'(tx_start), 0);
    tx_busy = 1'b1;
    set_req(1, 8'h3C);
    run_acks("t1_ack2", 1);
    repeat (19) tick();
    chk("t1_one_frame", sent.size(), 1);
    tx_busy = 1'b0;
    fall = cyc;
    repeat (GAP) tick();
    chk("t1_hold_data", 32'(tx_data), 32'hA5);
    wait_sent("t1_second_start", 2, 40);
    chk("t1_gap", last_start - fall, GAP + 3);
    chk("t1_second_data", 32'(sent[sent.size()-1]), 32'h3C);

    // Round-robin with requester 0 re-requesting
    do_reset();
    auto_busy = 1;
    set_req(0, 8'h11); set_req(1, 8'h22); set_req(2, 8'h33); set_req(3, 8'h44);
    ack_order.delete();
    renewed = 0;
    for (int b = 0; b < 20 && ack_order.size() < 5; b++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] === 1'b1) begin
          ack_order.push_back(i);
          if (i == 0 && !renewed) begin
            set_req(0, 8'h55);
            renewed = 1;
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
    chk("t2_ack_count", ack_order.size(), 5);
    for (int i = 0; i < ack_order.size() && i < 5; i++) chk("t2_ack_order", ack_order[i], i % 4);
    wait_sent("t2_frames", 5, 600);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    check_sent("t2_sent");

    // Full FIFO blocks grants until a pop, visible one cycle later
    do_reset();
    set_req(0, 8'hA0);
    run_acks("t3_first_ack", 1);
    wait_sent("t3_first_start", 1, 20);
    tx_busy = 1'b1;
    set_req(0, 8'hB0); set_req(1, 8'hB1); set_req(2, 8'hB2); set_req(3, 8'hB3);
    run_acks("t3_fill", 4);
    chk("t3_order0", ack_order.size() > 0 ? ack_order[0] : -1, 1);
    chk("t3_full", 32'(fifo_full), 1);
    chk("t3_count4", 32'(fifo_count), 4);
    set_req(1, 8'hC1);
    for (int b = 0; b < 5; b++) begin
      tick();
      chk("t3_no_ack_full", 32'(req_ack), 0);
    end
    tx_busy = 1'b0;
    auto_busy = 1;
    p = -1;
    a = -1;
    for (int b = 0; b < 60 && a < 0; b++) begin
      tick();
      if (p < 0 && fifo_count === 3'd3) p = cyc;
      if (req_ack !== '0) begin
        a = cyc;
        chk("t3_ack5", 32'(req_ack), 32'h2);
        chk("t3_count_after", 32'(fifo_count), 4);
        req[1] = 1'b0;
      end
    end
    chk("t3_ack_delay", a - p, 1);
    wait_sent("t3_frames", 6, 600);
    exp_q = '{8'hA0, 8'hB1, 8'hB2, 8'hB3, 8'hB0, 8'hC1};
    check_sent("t3_sent");

    // Flush with a frame in flight
    do_reset();
    set_req(0, 8'h5A);
    run_acks("t4_first_ack", 1);
    wait_sent("t4_first_start", 1, 20);
    tx_busy = 1'b1;
    set_req(1, 8'h01); set_req(2, 8'h02); set_req(3, 8'h03);
    run_acks("t4_fill", 3);
    chk("t4_count3", 32'(fifo_count), 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_count0", 32'(fifo_count), 0);
    chk("t4_empty", 32'(fifo_empty), 1);
    chk("t4_data_held", 32'(tx_data), 32'h5A);
    repeat (5) tick();
    tx_busy = 1'b0;
    repeat (40) tick();
    chk("t4_no_more_start", sent.size(), 1);
    chk("t4_data_final", 32'(tx_data), 32'h5A);

    // Busy timeout
    do_reset();
    set_req(0, 8'hD0); set_req(1, 8'hD1);
    run_acks("t5_acks", 2);
    wait_sent("t5_first_start", 1, 20);
    k0 = last_start;
    tmo_cyc = -1;
    for (int b = 0; b < TMO + 50 && tmo_cyc < 0; b++) begin
      tick();
      if (tmo_err === 1'b1) tmo_cyc = cyc;
    end
    chk("t5_tmo_time", tmo_cyc - k0, TMO);
    tick();
    chk("t5_tmo_pulse", 32'(tmo_err), 0);
    wait_sent("t5_second_start", 2, 60);
    chk("t5_relaunch", last_start - tmo_cyc, GAP + 2);
    chk("t5_second_data", 32'(sent[sent.size()-1]), 32'hD1);

    // Reset while waiting for the frame to finish
    do_reset();
    set_req(2, 8'hE2);
    run_acks("t6_first_ack", 1);
    wait_sent("t6_first_start", 1, 20);
    tx_busy = 1'b1;
    repeat (3) tick();
    set_req(3, 8'hE3); set_req(0, 8'hE0);
    run_acks("t6_fill", 2);
    chk("t6_count2", 32'(fifo_count), 2);
    rst = 1'b1;
    repeat (2) tick();
    chk("t6_rst_ack", 32'(req_ack), 0);
    chk("t6_rst_start", 32'(tx_start), 0);
    chk("t6_rst_data", 32'(tx_data), 0);
    chk("t6_rst_tmo", 32'(tmo_err), 0);
    chk("t6_rst_empty", 32'(fifo_empty), 1);
    rst = 1'b0;
    tick();
    tx_busy = 1'b0;
    set_req(0, 8'hF0); set_req(1, 8'hF1);
    tick();
    chk("t6_grant_req0", 32'(req_ack), 32'h1);
    req = '0;
    repeat (5) tick();

    // Randomized traffic against a round-robin / in-order reference
    do_reset();
    auto_busy = 1; busy_min = 2; busy_max = 12;
    rr_m = 0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) hold[i] = '0;
    for (int t = 0; t < 4000; t++) begin
      gen = (t < 1200);
      if (!gen && req == '0 && sent.size() == exp_q.size()) break;
      req_edge = req;
      tick();
      if (req_ack !== '0) begin
        g = rr_pick(req_edge, rr_m);
        chk("rand_grant", 32'(req_ack), (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
          exp_q.push_back(hold[g]);
          rr_m = (g + 1) % NREQ;
          if (gen && $urandom_range(0, 3) == 0) begin
            hold[g] = DW'($urandom);
            set_req(g, hold[g]);
          end else begin
            req[g] = 1'b0;
          end
        end
      end
      if (gen) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            hold[i] = DW'($urandom);
            set_req(i, hold[i]);
          end
        end
      end
    end
    repeat (40) tick();
    chk("rand_volume", 32'(exp_q.size() > 20), 1);
    check_sent("rand_sent");
    chk("rand_drained", 32'(fifo_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
